// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int LAT_DEFAULT = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_cnt.sv
// ============================================================================
// mem_arb_cnt : loadable down-counter that saturates at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_cnt
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : fetch/data arbiter and sequencer for a fixed-latency memory
// Optional alignment check: define MEM_ARB_ALIGN_CHK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_cancel,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        stall_if,
  output logic        stall_d,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

  arb_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        kill_q, kill_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;
  logic        busy;
  logic        d_go;
  logic        i_go;
  logic        d_mis;
  logic        i_mis;

  // A requester whose done is showing this cycle has already been served.
  assign d_go = (state_q == IDLE) && d_req && !d_done_q;
  assign i_go = (state_q == IDLE) && !d_go && if_req && !if_done_q && !if_cancel;

  mem_arb_cnt #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (LAT_M1),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    kill_d     = kill_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (d_go) begin
          if (d_mis) begin
            d_done_d = 1'b1;
          end else begin
            state_d  = BUSY_D;
            addr_d   = d_addr;
            wr_d     = d_wr;
            wdata_d  = d_wdata;
            cnt_load = 1'b1;
          end
        end else if (i_go) begin
          if (i_mis) begin
            if_done_d = 1'b1;
          end else begin
            state_d  = BUSY_I;
            addr_d   = if_addr;
            wr_d     = 1'b0;
            wdata_d  = '0;
            cnt_load = 1'b1;
          end
        end
      end
      BUSY_I: begin
        cnt_dec = 1'b1;
        if (if_cancel) begin
          kill_d = 1'b1;
        end
        // The memory cannot abort, so a squashed fetch still runs to the end.
        if (cnt_zero) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (!(kill_q || if_cancel)) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      BUSY_D: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d  = IDLE;
          d_done_d = 1'b1;
          if (!wr_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      kill_q     <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      kill_q     <= kill_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_ALIGN_CHK_EN
  logic err_q;

  assign d_mis = d_addr[0];
  assign i_mis = if_addr[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (d_go && d_mis) || (i_go && i_mis);
    end
  end

  assign err = err_q;
`else
  assign d_mis = 1'b0;
  assign i_mis = 1'b0;
  assign err   = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign mem_en    = busy;
  assign mem_wr    = busy && wr_q;
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Stalls follow the live requests but are forced low while reset is held.
  assign stall_if = rst && if_req && !if_done_q;
  assign stall_d  = rst && d_req && !d_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed vectors, corner sequences and a randomized run
// checked against a transaction-level model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_cancel = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, d_done, stall_if, stall_d, mem_en, mem_wr, err;

  int          checks = 0;
  int          errors = 0;
  int          salt   = 0;
  bit          dir_mode = 1'b1;
  bit          model_on = 1'b0;
  logic [15:0] dir_rdata = 16'hDEAD;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) salt <= salt + 1;

  // Random-phase memory data depends on the cycle, so late or early capture shows.
  assign mem_rdata = dir_mode ? dir_rdata : (mem_addr ^ {salt[7:0], 8'h00});

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rv;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int   en_cnt = 0;
    int   done_cyc = -1;
    bit   cmd_ok = 1'b1;
    bit   stall_ok = 1'b1;
    logic done_s, stall_s;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int i = 0; i <= LAT + 2; i++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (mem_addr !== v.addr || mem_wr !== v.wr) cmd_ok = 1'b0;
        if (v.wr && mem_wdata !== v.wdata) cmd_ok = 1'b0;
      end
      dir_rdata = (mem_en && en_cnt == LAT) ? v.rv : 16'hDEAD;
      done_s  = v.is_d ? d_done : if_done;
      stall_s = v.is_d ? stall_d : stall_if;
      if (done_s && done_cyc < 0) begin
        done_cyc = i;
        if (stall_s) stall_ok = 1'b0;
      end else if (done_cyc < 0 && !stall_s) begin
        stall_ok = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) begin
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      end
    end
    chki($sformatf("v%0d_mem_en_cycles", idx), en_cnt, LAT);
    chki($sformatf("v%0d_done_cycle", idx), done_cyc, LAT + 1);
    chk1($sformatf("v%0d_cmd_stable", idx), cmd_ok, 1'b1);
    chk1($sformatf("v%0d_stall", idx), stall_ok, 1'b1);
    chk16($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_own = 0;          // 0 none, 1 fetch, 2 data
  int          m_last = 0;         // salt value of the final busy cycle
  bit          m_killed = 1'b0, m_wr = 1'b0, m_ifd = 1'b0, m_dd = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;

  always @(posedge clk) begin : model
    bit nifd, ndd;
    nifd = 1'b0;
    ndd  = 1'b0;
    if (model_on) begin
      if (m_own == 0) begin
        if (d_req && !m_dd) begin
          m_own = 2; m_addr = d_addr; m_wr = d_wr; m_wdata = d_wdata; m_last = salt + LAT;
        end else if (if_req && !m_ifd && !if_cancel) begin
          m_own = 1; m_addr = if_addr; m_wr = 1'b0; m_wdata = '0; m_last = salt + LAT;
          m_killed = 1'b0;
        end
      end else begin
        if (m_own == 1 && if_cancel) m_killed = 1'b1;
        if (salt == m_last) begin
          if (m_own == 1 && !m_killed) begin
            nifd = 1'b1; m_ird = m_addr ^ {salt[7:0], 8'h00};
          end
          if (m_own == 2) begin
            ndd = 1'b1;
            if (!m_wr) m_drd = m_addr ^ {salt[7:0], 8'h00};
          end
          m_own = 0;
        end
      end
      m_ifd = nifd;
      m_dd  = ndd;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk1("r_mem_en", mem_en, m_own != 0);
      chk1("r_mem_wr", mem_wr, (m_own != 0) && m_wr);
      chk16("r_mem_addr", mem_addr, (m_own != 0) ? m_addr : 16'h0000);
      chk16("r_mem_wdata", mem_wdata, (m_own != 0) ? m_wdata : 16'h0000);
      chk1("r_if_done", if_done, m_ifd);
      chk1("r_d_done", d_done, m_dd);
      chk16("r_if_rdata", if_rdata, m_ird);
      chk16("r_d_rdata", d_rdata, m_drd);
      chk1("r_stall_if", stall_if, if_req && !m_ifd);
      chk1("r_stall_d", stall_d, d_req && !m_dd);
      chk1("r_err", err, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   dd, id, low_cnt, low_at, en_ok;
    bit   saw_ifd;
    logic [15:0] addr6;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 16'hA5A5};
    vecs[1] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1111, 16'h1111};
    vecs[2] = '{1'b1, 1'b1, 16'h0040, 16'h1234, 16'hBEEF, 16'h1111};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0F0F, 16'h0F0F};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b1, 16'h0002, 16'h0000, 16'h5555, 16'hFFFF};
    vecs[6] = '{1'b1, 1'b0, 16'h0600, 16'h0000, 16'h4242, 16'h4242};

    // Reset state, with requests raised to show stalls are held low.
    if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_stall_if", stall_if, 1'b0);
    chk1("rst_stall_d", stall_d, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk16("rst_if_rdata", if_rdata, 16'h0000);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Collision: data first, fetch granted in the d_done cycle.
    dd = -1; id = -1; low_cnt = 0; low_at = -1;
    @(posedge clk); #1;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200; if_req = 1'b1; if_addr = 16'h0100;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      dir_rdata = ~mem_addr;
      if (i >= 1 && i <= 2 * LAT + 1 && !mem_en) begin low_cnt++; low_at = i; end
      if (d_done && dd < 0) dd = i;
      if (if_done && id < 0) id = i;
      @(posedge clk); #1;
      if (dd >= 0) d_req = 1'b0;
      if (id >= 0) if_req = 1'b0;
    end
    chki("col_d_done", dd, LAT + 1);
    chki("col_if_done", id, 2 * LAT + 2);
    chki("col_idle_cycles", low_cnt, 1);
    chki("col_idle_at", low_at, LAT + 1);
    chk16("col_d_rdata", d_rdata, 16'hFDFF);
    chk16("col_if_rdata", if_rdata, 16'hFEFF);

    // Cancel in the 2nd BUSY_I cycle with a data request pending.
    dd = -1; en_ok = 0; saw_ifd = 1'b0; addr6 = '0; dir_rdata = 16'h9999;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0300;
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= LAT && mem_en && mem_addr === 16'h0300) en_ok++;
      if (if_done) saw_ifd = 1'b1;
      if (d_done && dd < 0) dd = i;
      if (i == LAT + 2) addr6 = mem_addr;
      @(posedge clk); #1;
      if (i == 1) begin if_cancel = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400; end
      if (i == 2) begin if_cancel = 1'b0; if_req = 1'b0; end
      if (dd >= 0) d_req = 1'b0;
    end
    chki("cxl_busy_cycles", en_ok, LAT);
    chk1("cxl_no_if_done", saw_ifd, 1'b0);
    chk16("cxl_if_rdata_kept", if_rdata, 16'hFEFF);
    chk16("cxl_d_grant_addr", addr6, 16'h0400);
    chki("cxl_d_done", dd, 2 * LAT + 2);
    chk16("cxl_d_rdata", d_rdata, 16'h9999);

    // Reset asserted in the 3rd BUSY_D cycle.
    @(posedge clk); #1;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk1("rmid_busy_before", mem_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b1;
    #1;
    chk1("rmid_mem_en", mem_en, 1'b0);
    chk1("rmid_stall_d", stall_d, 1'b0);
    chk1("rmid_stall_if", stall_if, 1'b0);
    chk1("rmid_d_done", d_done, 1'b0);
    chk16("rmid_d_rdata", d_rdata, 16'h0000);
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("rmid_idle_after", mem_en, 1'b0);
    run_vec(6, vecs[6]);

`ifdef MEM_ARB_ALIGN_CHK_EN
    // Misaligned data address: immediate error/done, no memory access.
    dd = -1; en_ok = 0; low_cnt = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0003;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (mem_en) en_ok++;
      if (err) low_cnt++;
      if (err && d_done && dd < 0) dd = i;
      @(posedge clk); #1;
      if (dd >= 0) d_req = 1'b0;
    end
    chki("aln_done_cycle", dd, 1);
    chki("aln_mem_en", en_ok, 0);
    chki("aln_err_cycles", low_cnt, 1);
    chk16("aln_d_rdata", d_rdata, 16'h4242);
`endif

    // Randomized traffic against the model, starting from a fresh reset.
    dir_mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; model_on = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if_cancel = 1'b0;
      if (!if_req || if_done) begin
        if_req  = ($urandom % 3) != 0;
        if_addr = 16'($urandom) & 16'hFFFE;
      end else if ($urandom % 10 == 0) begin
        if_cancel = 1'b1;
        if_addr   = 16'($urandom) & 16'hFFFE;
      end
      if (!d_req || d_done) begin
        d_req   = ($urandom % 3) == 0;
        d_wr    = 1'($urandom % 2);
        d_addr  = 16'($urandom) & 16'hFFFE;
        d_wdata = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; if_cancel = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    model_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
